// File: rtl/n0prime_param.sv
// Montgomery constant n0' = -n^-1 mod 2^W from the low word of the modulus.
// MODE 0 resolves one inverse bit per cycle; MODE 1 uses Newton iteration.
module n0prime_param #(
    parameter int N_W  = 1025,
    parameter int W    = 32,
    parameter int MODE = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [N_W-1:0] n,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [W-1:0]   n0prime
);

    // Smallest k with 3*2^k >= w: each Newton step doubles the correct bits,
    // starting from 3 correct bits (x = n0 is its own inverse mod 8).
    function automatic int calc_k(input int w);
        int k;
        k = 0;
        for (int j = 0; j < 20; j++) begin
            if ((3 << j) < w) k = j + 1;
        end
        return k;
    endfunction

    localparam int K  = calc_k(W);
    localparam int IW = $clog2(W);
    localparam int KW = $clog2(K) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_CALC,
        S_MUL1,
        S_MUL2,
        S_FIN
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  n0, n0_nxt;
    logic [W-1:0]  acc, acc_nxt;
    logic [W-1:0]  t, t_nxt;
    logic [IW-1:0] idx, idx_nxt;
    logic [KW-1:0] k_cnt, k_nxt;
    logic [W-1:0]  res_q, res_nxt;
    logic          err_q, err_nxt;
    logic          done_q, done_nxt;
    logic [W-1:0]  mult_a, mult_b, prod;

    generate
        if (N_W > W) begin : g_hi
            logic unused_hi;
            assign unused_hi = ^n[N_W-1:W];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            n0     <= '0;
            acc    <= '0;
            t      <= '0;
            idx    <= '0;
            k_cnt  <= '0;
            res_q  <= '0;
            err_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            n0     <= n0_nxt;
            acc    <= acc_nxt;
            t      <= t_nxt;
            idx    <= idx_nxt;
            k_cnt  <= k_nxt;
            res_q  <= res_nxt;
            err_q  <= err_nxt;
            done_q <= done_nxt;
        end
    end

    // One truncated W x W multiplier: n0*acc in CALC/MUL1, acc*(2-t) in MUL2.
    always_comb begin
        mult_a = n0;
        mult_b = acc;
        if (state == S_MUL2) begin
            mult_a = acc;
            mult_b = W'(2) - t;
        end
        prod = mult_a * mult_b;
    end

    always_comb begin
        state_nxt = state;
        n0_nxt    = n0;
        acc_nxt   = acc;
        t_nxt     = t;
        idx_nxt   = idx;
        k_nxt     = k_cnt;
        res_nxt   = res_q;
        err_nxt   = err_q;
        done_nxt  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    n0_nxt    = n[W-1:0];
                    state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!n0[0]) begin
                    err_nxt   = 1'b1;
                    res_nxt   = '0;
                    done_nxt  = 1'b1;
                    state_nxt = S_IDLE;
                end else if (MODE == 0) begin
                    acc_nxt   = W'(1);
                    idx_nxt   = IW'(1);
                    state_nxt = S_CALC;
                end else begin
                    acc_nxt   = n0;
                    k_nxt     = '0;
                    state_nxt = S_MUL1;
                end
            end
            S_CALC: begin
                // Bit idx of n0*y decides whether y needs 2^idx to keep n0*y = 1.
                if (prod[idx]) acc_nxt = acc + (W'(1) << idx);
                if (idx == IW'(W - 1)) begin
                    state_nxt = S_FIN;
                end else begin
                    idx_nxt = idx + IW'(1);
                end
            end
            S_MUL1: begin
                t_nxt     = prod;
                state_nxt = S_MUL2;
            end
            S_MUL2: begin
                acc_nxt = prod;
                k_nxt   = k_cnt + KW'(1);
                if (k_cnt == KW'(K - 1)) begin
                    state_nxt = S_FIN;
                end else begin
                    state_nxt = S_MUL1;
                end
            end
            S_FIN: begin
                res_nxt   = ~acc + W'(1);
                err_nxt   = 1'b0;
                done_nxt  = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy    = (state != S_IDLE);
    assign done    = done_q;
    assign err     = err_q;
    assign n0prime = res_q;

endmodule
